// File: rtl/isolator_pkg.sv
// Shared definitions for the isolator shift-register link.
//
// Contents:
//   link_state_t    - frame sequencer states (IDLE, SHIFT, LATCH)
//   LINK_FRAME_BITS - serial bits per frame in each direction
//   CS_N_PAD        - fixed upper nibble of the outgoing chip-select word
//   HWCON_PAD       - fixed upper nibble of the outgoing HWCON word
//   frame_word()    - builds an outgoing 8-bit word from pad + slot nibble
package isolator_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } link_state_t;

   localparam int         LINK_FRAME_BITS = 8;
   localparam logic [3:0] CS_N_PAD        = 4'hF;
   localparam logic [3:0] HWCON_PAD       = 4'h0;

   // The isolator's upper output bits are unused, so they are padded to an
   // inactive level (cs_n high, hwcon low) above the per-slot nibble.
   function automatic logic [7:0] frame_word(input logic [3:0] pad,
                                             input logic [3:0] slots);
      return {pad, slots};
   endfunction

endpackage

// File: rtl/isolator_sclk_gen.sv
// Bit-period timing for the isolator link.
//
// A phase counter runs through 2*CLK_DIV clk cycles per bit period. The
// rise/fall strikes are high in the cycle before the clk edge at which sclk
// goes high (phase 0) or low (phase CLK_DIV), so the owner can act on the
// same edge the serial clock changes.
//
// Ports:
//   clk, reset_n - system clock, synchronous active-low reset
//   run          - count phases; when low the counter parks at phase 0
//   hold_low     - force sclk low on the next edge (idle, latch, reset)
//   sclk         - registered serial clock level
//   rise, fall   - one-cycle strikes announcing the next sclk edge
module isolator_sclk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic run,
   input  logic hold_low,
   output logic sclk,
   output logic rise,
   output logic fall
);

   localparam int             PW   = $clog2(2 * CLK_DIV);
   localparam logic [PW-1:0] LAST = PW'(2 * CLK_DIV - 1);
   localparam logic [PW-1:0] HALF = PW'(CLK_DIV);

   logic [PW-1:0] phase;

   // The counter holds the phase of the upcoming cycle, so the strikes lead
   // the actual sclk transition by exactly one clk.
   assign rise = (phase == '0);
   assign fall = (phase == HALF);

   // Phase counter and the sclk level it implies; parking at phase 0 while
   // stopped means a start request always begins with an immediate rise.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         phase <= '0;
         sclk  <= 1'b0;
      end else begin
         if (!run || phase == LAST)
            phase <= '0;
         else
            phase <= phase + PW'(1);

         if (hold_low)
            sclk <= 1'b0;
         else if (rise)
            sclk <= 1'b1;
         else if (fall)
            sclk <= 1'b0;
      end
   end

endmodule

// File: rtl/isolator_link_ctrl.sv
// FPGA-side controller for the isolator board shift-register link.
//
// Each frame shifts 8 chip-select and 8 HWCON bits out (MSB first) while
// shifting 8 dirchan and 8 hwflag bits in, then spends one bit period with
// srclk high so the isolator latches outputs and reloads its inputs.
//
// Ports:
//   clk, reset_n              - system clock, synchronous active-low reset
//   enable                    - run frames back to back while high
//   cs_n_slots, hwcon_slots   - per-slot parallel values to send
//   sclk, srclk               - serial clock and latch/load strobe
//   cs_n, hwcon               - serial outgoing data
//   dirchan, hwflag           - serial incoming data
//   slot_dir, slot_chan,
//   slot_hwflag               - decoded slot status from the last full frame
//   status_valid              - one-cycle pulse when the status updates
module isolator_link_ctrl
   import isolator_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic [3:0] cs_n_slots,
   input  logic [3:0] hwcon_slots,
   output logic       sclk,
   output logic       srclk,
   output logic       cs_n,
   output logic       hwcon,
   input  logic       dirchan,
   input  logic       hwflag,
   output logic [3:0] slot_dir,
   output logic [3:0] slot_chan,
   output logic [3:0] slot_hwflag,
   output logic       status_valid
);

   link_state_t state;
   logic [7:0]  cs_sr;
   logic [7:0]  hw_sr;
   logic [7:0]  dc_cap;
   logic [3:0]  hf_cap;
   logic [3:0]  bit_cnt;
   logic        priming;
   logic        rise;
   logic        fall;
   logic        run;
   logic        hold_low;
   logic        frame_done;

   // Serial data comes straight off the top of the output shift registers.
   assign cs_n       = cs_sr[7];
   assign hwcon      = hw_sr[7];
   assign frame_done = (bit_cnt == 4'(LINK_FRAME_BITS));

   // The bit clock runs through SHIFT and LATCH and stops at the LATCH exit
   // that returns to IDLE, so a later start sees phase 0 at once. sclk is
   // held low once all bits are shifted and for the whole latch period.
   always_comb begin
      run = 1'b0;
      unique case (state)
         IDLE:    run = enable;
         SHIFT:   run = 1'b1;
         LATCH:   run = !(rise && !enable);
         default: run = 1'b0;
      endcase
      hold_low = !run || (state == SHIFT && frame_done);
   end

   isolator_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk_gen (
      .clk      (clk),
      .reset_n  (reset_n),
      .run      (run),
      .hold_low (hold_low),
      .sclk     (sclk),
      .rise     (rise),
      .fall     (fall)
   );

   // Frame sequencer. Outgoing bits change and incoming bits are captured on
   // the sclk fall, giving the isolator half a bit period of setup before it
   // samples on the next rise. The last bit is not shifted past, so bit 0
   // stays on the line until the latch. The hwflag capture only keeps the
   // low nibble; the padding nibble shifts through and drops out the top.
   // Status from a priming frame is discarded because the isolator's input
   // registers were not loaded before it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         cs_sr        <= 8'hFF;
         hw_sr        <= 8'h00;
         dc_cap       <= 8'h00;
         hf_cap       <= 4'h0;
         bit_cnt      <= 4'd0;
         priming      <= 1'b1;
         srclk        <= 1'b0;
         slot_dir     <= 4'h0;
         slot_chan    <= 4'h0;
         slot_hwflag  <= 4'h0;
         status_valid <= 1'b0;
      end else begin
         status_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (enable) begin
                  cs_sr   <= frame_word(CS_N_PAD, cs_n_slots);
                  hw_sr   <= frame_word(HWCON_PAD, hwcon_slots);
                  bit_cnt <= 4'd0;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               if (fall && !frame_done) begin
                  dc_cap  <= {dc_cap[6:0], dirchan};
                  hf_cap  <= {hf_cap[2:0], hwflag};
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt != 4'(LINK_FRAME_BITS - 1)) begin
                     cs_sr <= {cs_sr[6:0], 1'b1};
                     hw_sr <= {hw_sr[6:0], 1'b0};
                  end
               end
               if (rise && frame_done) begin
                  state   <= LATCH;
                  srclk   <= 1'b1;
                  priming <= 1'b0;
                  if (!priming) begin
                     slot_dir     <= dc_cap[3:0];
                     slot_chan    <= dc_cap[7:4];
                     slot_hwflag  <= hf_cap;
                     status_valid <= 1'b1;
                  end
               end
            end
            LATCH: begin
               if (rise) begin
                  srclk <= 1'b0;
                  if (enable) begin
                     cs_sr   <= frame_word(CS_N_PAD, cs_n_slots);
                     hw_sr   <= frame_word(HWCON_PAD, hwcon_slots);
                     bit_cnt <= 4'd0;
                     state   <= SHIFT;
                  end else begin
                     cs_sr   <= 8'hFF;
                     hw_sr   <= 8'h00;
                     priming <= 1'b1;
                     state   <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_isolator_link_ctrl.sv
// Self-checking bench for isolator_link_ctrl with CLK_DIV = 2 (36-cycle frame).
//
// A behavioural isolator model sits on the serial link: slot 2 in DAC8 and
// slot 0 in ADC2 (dir = 4'b0001, chan = 4'b0100). Stimulus pushes expected
// latch events and status updates (with their clk cycle) into queues; a
// monitor pops and compares whenever srclk rises or status_valid pulses.
module tb_isolator_link_ctrl;

   localparam int CLK_DIV = 2;

   typedef struct {
      int         cyc;
      logic [3:0] dir;
      logic [3:0] chan;
      logic [3:0] flag;
   } status_exp_t;

   typedef struct {
      int         cyc;
      logic [7:0] cs;
      logic [7:0] hw;
   } latch_exp_t;

   logic       clk;
   logic       reset_n;
   logic       enable;
   logic [3:0] cs_n_slots;
   logic [3:0] hwcon_slots;
   logic       sclk;
   logic       srclk;
   logic       cs_n;
   logic       hwcon;
   logic       dirchan;
   logic       hwflag;
   logic [3:0] slot_dir;
   logic [3:0] slot_chan;
   logic [3:0] slot_hwflag;
   logic       status_valid;

   int cyc      = 0;
   int base     = 0;
   int checks   = 0;
   int failures = 0;

   status_exp_t status_q[$];
   latch_exp_t  latch_q[$];
   status_exp_t s_exp;
   latch_exp_t  l_exp;
   status_exp_t s_new;
   latch_exp_t  l_new;

   logic [7:0] iso_cs_sr;
   logic [7:0] iso_hw_sr;
   logic [7:0] iso_cs_latched;
   logic [7:0] iso_hw_latched;
   logic [7:0] iso_dc_sr;
   logic [7:0] iso_hf_sr;
   logic [3:0] iso_dir;
   logic [3:0] iso_chan;
   logic [3:0] iso_flag;
   logic       srclk_prev;

   isolator_link_ctrl #(
      .CLK_DIV (CLK_DIV)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .cs_n_slots   (cs_n_slots),
      .hwcon_slots  (hwcon_slots),
      .sclk         (sclk),
      .srclk        (srclk),
      .cs_n         (cs_n),
      .hwcon        (hwcon),
      .dirchan      (dirchan),
      .hwflag       (hwflag),
      .slot_dir     (slot_dir),
      .slot_chan    (slot_chan),
      .slot_hwflag  (slot_hwflag),
      .status_valid (status_valid)
   );

   // Free-running clock and a cycle counter used to time expected events.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Isolator output side: samples serial data just after each sclk rise
   // and latches the shifted words on the srclk rise.
   always @(posedge sclk) begin
      #1;
      iso_cs_sr = {iso_cs_sr[6:0], cs_n};
      iso_hw_sr = {iso_hw_sr[6:0], hwcon};
   end

   // Isolator input side: loads parallel inputs on srclk and presents the
   // next bit after each sclk fall. The hwflag upper nibble carries junk.
   always @(negedge sclk) begin
      iso_dc_sr = iso_dc_sr << 1;
      iso_hf_sr = iso_hf_sr << 1;
   end

   always @(posedge srclk) begin
      iso_cs_latched = iso_cs_sr;
      iso_hw_latched = iso_hw_sr;
      iso_dc_sr      = {iso_chan, iso_dir};
      iso_hf_sr      = {4'hC, iso_flag};
   end

   assign dirchan = iso_dc_sr[7];
   assign hwflag  = iso_hf_sr[7];

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  name, actual, expected, cyc - base);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic [3:0] cs,
                                input logic [3:0] hw);
      enable      = en;
      cs_n_slots  = cs;
      hwcon_slots = hw;
   endtask

   task automatic expectLatch(input int off, input logic [7:0] cs,
                              input logic [7:0] hw);
      l_new.cyc = base + off;
      l_new.cs  = cs;
      l_new.hw  = hw;
      latch_q.push_back(l_new);
   endtask

   task automatic expectStatus(input int off, input logic [3:0] dir,
                               input logic [3:0] chan, input logic [3:0] flag);
      s_new.cyc  = base + off;
      s_new.dir  = dir;
      s_new.chan = chan;
      s_new.flag = flag;
      status_q.push_back(s_new);
   endtask

   task automatic waitUntil(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_sclk"}, sclk, 0);
      checkOutput({tag, "_srclk"}, srclk, 0);
      checkOutput({tag, "_cs_n"}, cs_n, 1);
      checkOutput({tag, "_hwcon"}, hwcon, 0);
      checkOutput({tag, "_slot_dir"}, slot_dir, 0);
      checkOutput({tag, "_slot_chan"}, slot_chan, 0);
      checkOutput({tag, "_slot_hwflag"}, slot_hwflag, 0);
      checkOutput({tag, "_status_valid"}, status_valid, 0);
   endtask

   // Scoreboard monitor: every srclk rise and status_valid pulse must match
   // the next queued expectation, including the clk cycle it lands on.
   always @(negedge clk) begin
      if (status_valid === 1'b1) begin
         if (status_q.size() == 0) begin
            checkOutput("unexpected_status_valid", status_valid, 0);
         end else begin
            s_exp = status_q.pop_front();
            checkOutput("status_cycle", cyc - base, s_exp.cyc - base);
            checkOutput("slot_dir", slot_dir, s_exp.dir);
            checkOutput("slot_chan", slot_chan, s_exp.chan);
            checkOutput("slot_hwflag", slot_hwflag, s_exp.flag);
         end
      end
      if (srclk === 1'b1 && srclk_prev !== 1'b1) begin
         if (latch_q.size() == 0) begin
            checkOutput("unexpected_srclk", srclk, 0);
         end else begin
            l_exp = latch_q.pop_front();
            checkOutput("latch_cycle", cyc - base, l_exp.cyc - base);
            checkOutput("latched_cs_n", iso_cs_latched, l_exp.cs);
            checkOutput("latched_hwcon", iso_hw_latched, l_exp.hw);
         end
      end
      srclk_prev = srclk;
   end

   initial begin
      iso_cs_sr      = 8'h00;
      iso_hw_sr      = 8'h00;
      iso_cs_latched = 8'h00;
      iso_hw_latched = 8'h00;
      iso_dc_sr      = 8'h00;
      iso_hf_sr      = 8'h00;
      iso_dir        = 4'b0001;
      iso_chan       = 4'b0100;
      iso_flag       = 4'b1001;
      srclk_prev     = 1'b0;
      reset_n        = 1'b0;
      applyStimulus(1'b0, 4'hF, 4'h0);

      repeat (3) @(negedge clk);
      checkResetOutputs("reset");

      // Release reset with enable high: SHIFT entry is the next edge (t=0).
      applyStimulus(1'b1, 4'b1011, 4'h0);
      reset_n = 1'b1;
      base    = cyc + 1;
      expectLatch(32, 8'hFB, 8'h00);

      // hwcon 5 before the frame-1 snapshot, then A in the middle of frame 1.
      waitUntil(base + 20);
      applyStimulus(1'b1, 4'b1011, 4'h5);
      expectLatch(68, 8'hFB, 8'h05);
      expectStatus(68, 4'b0001, 4'b0100, 4'b1001);

      waitUntil(base + 45);
      applyStimulus(1'b1, 4'b1011, 4'hA);
      expectLatch(104, 8'hFB, 8'h0A);
      expectStatus(104, 4'b0001, 4'b0100, 4'b1001);

      // New hwflag is loaded at the t=104 latch and reported at t=140.
      waitUntil(base + 80);
      iso_flag = 4'b0110;
      expectLatch(140, 8'hFB, 8'h0A);
      expectStatus(140, 4'b0001, 4'b0100, 4'b0110);

      // Drop enable in bit 3 of the frame starting at t=108.
      waitUntil(base + 120);
      applyStimulus(1'b0, 4'b1011, 4'hA);

      waitUntil(base + 150);
      checkOutput("idle_sclk", sclk, 0);
      checkOutput("idle_srclk", srclk, 0);
      applyStimulus(1'b0, 4'b0110, 4'hA);

      waitUntil(base + 155);
      checkOutput("idle_sclk_late", sclk, 0);
      checkOutput("idle_cs_n", cs_n, 1);

      // Re-enable: SHIFT entry at t=160 is a priming frame.
      waitUntil(base + 159);
      applyStimulus(1'b1, 4'b0110, 4'hA);
      expectLatch(192, 8'hF6, 8'h0A);
      expectLatch(228, 8'hF6, 8'h0A);
      expectStatus(228, 4'b0001, 4'b0100, 4'b0110);

      // Reset during bit 5 of the frame starting at t=232.
      waitUntil(base + 252);
      reset_n = 1'b0;
      @(negedge clk);
      checkResetOutputs("midframe_reset");
      checkOutput("iso_cs_kept", iso_cs_latched, 8'hF6);
      checkOutput("iso_hw_kept", iso_hw_latched, 8'h0A);

      waitUntil(base + 280);
      checkOutput("pending_latches", latch_q.size(), 0);
      checkOutput("pending_status", status_q.size(), 0);
      checkOutput("iso_cs_final", iso_cs_latched, 8'hF6);

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, failures);
      $finish;
   end

endmodule

// File: doc/isolator_link_ctrl.md
# isolator_link_ctrl

FPGA-side controller for the isolator board's shift-register link. Each frame it serializes per-slot chip selects and HWCON bits into the isolator's output shift registers, and deserializes slot direction, channel-count and HWFLAG bits from the isolator's input shift registers. It generates `sclk` and `srclk` and presents decoded slot status to the rest of the design.

## Interface
Parameters:
- `CLK_DIV`, default 4: `sclk` half-period in `clk` cycles; must be ≥ 1.

Ports:
- `clk` — input, 1 bit: system clock; the only clock.
- `reset_n` — input, 1 bit: synchronous, active-low reset.
- `enable` — input, 1 bit: run frames continuously while high.
- `cs_n_slots` — input, 4 bits: per-slot chip select, active low.
- `hwcon_slots` — input, 4 bits: per-slot HWCON level.
- `sclk` — output, 1 bit: serial shift clock to isolator.
- `srclk` — output, 1 bit: parallel latch/load strobe to isolator.
- `cs_n` — output, 1 bit: serial chip-select data, MSB first.
- `hwcon` — output, 1 bit: serial HWCON data, MSB first.
- `dirchan` — input, 1 bit: serial {chan[3:0], dir[3:0]}, MSB first.
- `hwflag` — input, 1 bit: serial {4'h0, hwflag[3:0]}, MSB first.
- `slot_dir` — output, 4 bits: last valid direction bits.
- `slot_chan` — output, 4 bits: last valid channel-mode bits.
- `slot_hwflag` — output, 4 bits: last valid HWFLAG bits.
- `status_valid` — output, 1 bit: one-`clk` pulse when the status outputs update.

## Operation
- States: IDLE, SHIFT, LATCH.
- IDLE → SHIFT when `enable` = 1.
  - In the same cycle, snapshot the outgoing words: {4'hF, `cs_n_slots`} and {4'h0, `hwcon_slots`}.
  - Upper cs_n nibble is always 1; upper hwcon nibble is always 0.
- SHIFT: 8 bit periods. Bit 7 of each outgoing word is sent first. Each incoming bit is shifted into an 8-bit capture register, MSB first.
- LATCH: one bit period.
  - `srclk` is high and `sclk` is low for the whole bit period.
  - The isolator latches the shifted word and loads fresh parallel inputs.
- LATCH exit:
  - `enable` = 1 → take a new snapshot and go to SHIFT.
  - `enable` = 0 → go to IDLE.
  - `enable` is ignored mid-frame; a started frame always completes through LATCH.
- Priming frame: the first SHIFT after reset or after IDLE carries unloaded input registers.
  - Its captured data is discarded.
  - `status_valid` is not pulsed and the status outputs are unchanged.
- Status update: on each non-priming frame, at the last clk cycle of SHIFT:
  - `slot_dir` ← capture[3:0]
  - `slot_chan` ← dirchan capture[7:4]
  - `slot_hwflag` ← hwflag capture[3:0]
  - `status_valid` pulses for 1 cycle.
- Reset values:
  - `sclk`, `srclk`, `hwcon` = 0; `cs_n` = 1.
  - `slot_dir`, `slot_chan`, `slot_hwflag` = 0; `status_valid` = 0.
  - State = IDLE, priming flag set.
- Reset mid-frame: outputs return to reset values on the next clk edge and no `srclk` edge is produced. The isolator keeps its previously latched cs_n/hwcon.
- Mid-frame changes to `cs_n_slots`/`hwcon_slots` are ignored until the next snapshot.

## Timing
- Bit period = 2·`CLK_DIV` clk cycles. `sclk` rises at phase 0 and falls at phase `CLK_DIV`.
- Outgoing bit 7 is driven at SHIFT entry. Bit 7−k is driven at the `sclk` fall after rise k (k = 1..7). This gives half a bit period of setup before the isolator samples on the `sclk` rise.
- Incoming bits are captured at each `sclk` fall in SHIFT; the first capture is bit 7.
- Frame = 9 bit periods = 18·`CLK_DIV` clk cycles. The LATCH `srclk` rise occurs 16·`CLK_DIV` cycles after SHIFT entry.
- Parallel input changes reach the isolator outputs (`srclk` rise) within 2 frames.
- Status reflects isolator inputs sampled at the previous LATCH `srclk` rise.

## Structure
- Shared package `isolator_pkg` holds:
  - the `link_state_t` enum (IDLE/SHIFT/LATCH);
  - `LINK_FRAME_BITS` = 8;
  - `CS_N_PAD` = 4'hF and `HWCON_PAD` = 4'h0.
- One sub-module, `isolator_sclk_gen`:
  - phase counter with `CLK_DIV` prescale;
  - outputs a `sclk` level plus one-cycle rise/fall strikes.
- Shift registers, bit counter and FSM are inline in the top module.

## Test plan
All scenarios use `CLK_DIV` = 2 against the isolator model with slot 2 in DAC8 and slot 0 in ADC2.
- Reset release, `enable` = 1, `cs_n_slots` = 4'b1011 → after 2nd `srclk` rise, isolator slot_cs_n = 4'b1011. No `status_valid` in frame 1. First `status_valid` at clk 36+32 from SHIFT entry with `slot_dir`[0] = 1 and `slot_chan`[2] = 1.
- `hwcon_slots` = 4'h5, then 4'hA mid-frame → next latch shows 4'h5; the following latch shows 4'hA, 36 cycles later.
- `enable` drops at SHIFT bit 3 → frame completes, one `srclk` pulse, then IDLE. `sclk`/`srclk` stay low. Re-enable → priming frame with no `status_valid`.
- Assert `reset_n` = 0 during SHIFT bit 5 → next cycle: `cs_n` = 1, `sclk` = `srclk` = 0, status = 0. Isolator latched outputs unchanged.
- Force isolator `hwflag` = 4'b0110 → `slot_hwflag` = 4'b0110 on the next non-priming `status_valid`. Upper-nibble bits ignored.
